decode_stage: RTL



---
 rtl/Uop.sv | 79 +++++++
 rtl/pipeline_if.sv | 9 +
 rtl/RegFile.sv | 41 ++++
 rtl/decode_stage.sv | 138 +++++++++++++
 4 files changed

// File: rtl/Uop.sv
// Uop: shared micro-op types, opcodes and the decode helper functions.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package Uop;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] val_t;
  typedef logic [4:0]      reg_t;

  typedef enum logic [1:0] {
    EX_NONE          = 2'd0,
    EX_FETCH_FAULT   = 2'd1,
    EX_ILLEGAL_INSTR = 2'd2
  } ex_t;

  typedef enum logic [1:0] {
    FU_NONE   = 2'd0,
    FU_INTALU = 2'd1
  } fu_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } intalu_op_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  typedef struct packed {
    logic [31:0] instr;
    val_t        pc;
    ex_t         ex;
  } fetch_t;

  typedef struct packed {
    val_t       pc;
    ex_t        ex;
    fu_t        fu;
    intalu_op_t op;
    reg_t       rd;
    reg_t       rs1;
    reg_t       rs2;
    val_t       rs1val;
    val_t       rs2val;
    val_t       imm;
    logic       immValid;
  } decode_t;

  // funct7[5] selects SUB only for register-register ops; it selects SRA for both forms.
  function automatic intalu_op_t intaluOp(input logic [2:0] funct3, input logic f7b5,
                                          input logic isOpImm);
    case (funct3)
      3'b000:  return (!isOpImm && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // For OP-IMM, funct7 is immediate data except on the shift forms.
  function automatic logic funct7Legal(input logic [2:0] funct3, input logic [6:0] funct7,
                                       input logic isOpImm);
    if (isOpImm) begin
      if (funct3 == 3'b001) return funct7 == 7'b0000000;
      if (funct3 == 3'b101) return (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      return 1'b1;
    end
    if (funct7 == 7'b0000000) return 1'b1;
    if (funct7 == 7'b0100000) return (funct3 == 3'b000) || (funct3 == 3'b101);
    return 1'b0;
  endfunction

endpackage

// File: rtl/pipeline_if.sv
// pipeline_if: valid/stall handshake between adjacent pipeline stages.
// Latency: none (wires only).
// Backpressure: stall flows from the consumer back to the producer.
interface pipeline_if;
  logic valid;
  logic stall;
  modport Upstream   (input valid, output stall);
  modport Downstream (output valid, input stall);
endinterface

// File: rtl/RegFile.sv
// RegFile: architectural registers, 2 async read ports, 1 sync write port, x0 reads zero.
// Latency: reads combinational; a same-cycle write is forwarded to the readers.
// Backpressure: none; writes are always accepted.
module RegFile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1Val,
  output logic [XLEN-1:0] rs2Val,
  input  logic            wbValid,
  input  logic [AW-1:0]   wbRd,
  input  logic [XLEN-1:0] wbVal
);

  logic [XLEN-1:0] regs [NREGS];

  // Clear on reset; x0 is never written so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wbValid && wbRd != '0) begin
      regs[wbRd] <= wbVal;
    end
  end

  // Read with write-through so decode sees a writeback landing this same cycle.
  always_comb begin
    rs1Val = regs[rs1];
    rs2Val = regs[rs2];
    if (rs1 == '0)                      rs1Val = '0;
    else if (wbValid && wbRd == rs1)    rs1Val = wbVal;
    if (rs2 == '0)                      rs2Val = '0;
    else if (wbValid && wbRd == rs2)    rs2Val = wbVal;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes RV32I integer-ALU ops, reads operands, issues a registered decode_t.
// Latency: 1 cycle from accepted input to uopOut/d.valid.
// Backpressure: 1-deep skid buffer absorbs the uop in flight when d.stall rises; u.stall follows a cycle later.
module decode_stage
  import Uop::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_if.Upstream        u,
  pipeline_if.Downstream      d,
  input  fetch_t              uopIn,
  output decode_t             uopOut,
  input  logic                wbValid,
  input  logic [4:0]          wbRd,
  input  logic [XLEN-1:0]     wbVal
);

  logic    bufFull;
  logic    bufValid;
  fetch_t  bufUop;
  logic    outValid;

  fetch_t  srcUop;
  logic    srcValid;
  decode_t dec;
  decode_t issueUop;
  logic [XLEN-1:0] rs1Val;
  logic [XLEN-1:0] rs2Val;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign u.stall  = bufFull;
  assign d.valid  = outValid;

  // While the skid buffer holds a uop it, not the live input, is what gets decoded.
  assign srcUop   = bufFull ? bufUop   : uopIn;
  assign srcValid = bufFull ? bufValid : u.valid;

  assign instr  = srcUop.instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Combinational decode of the selected source; operand values are attached below.
  always_comb begin
    dec          = '0;
    dec.pc       = srcUop.pc;
    dec.ex       = EX_NONE;
    dec.fu       = FU_NONE;
    dec.op       = ALU_ADD;
    dec.rd       = instr[11:7];
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.imm      = '0;
    dec.immValid = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7Legal(funct3, funct7, 1'b0)) begin
          dec.fu = FU_INTALU;
          dec.op = intaluOp(funct3, funct7[5], 1'b0);
        end else begin
          dec.ex = EX_ILLEGAL_INSTR;
        end
      end
      OPC_OPIMM: begin
        if (funct7Legal(funct3, funct7, 1'b1)) begin
          dec.fu       = FU_INTALU;
          dec.op       = intaluOp(funct3, funct7[5], 1'b1);
          dec.imm      = {{20{instr[31]}}, instr[31:20]};
          dec.immValid = 1'b1;
        end else begin
          dec.ex = EX_ILLEGAL_INSTR;
        end
      end
      OPC_LUI: begin
        dec.fu       = FU_INTALU;
        dec.op       = ALU_ADD;
        dec.rs1      = '0;
        dec.imm      = {instr[31:12], 12'b0};
        dec.immValid = 1'b1;
      end
      default: dec.ex = EX_ILLEGAL_INSTR;
    endcase
    if (dec.immValid) dec.rs2 = '0;
    // A fault raised upstream wins over anything decoded from the word.
    if (srcUop.ex != EX_NONE) begin
      dec.ex = srcUop.ex;
      dec.fu = FU_NONE;
    end
  end

  RegFile #(.XLEN(XLEN), .NREGS(NREGS)) rf (
    .clk     (clk),
    .rst     (rst),
    .rs1     (dec.rs1),
    .rs2     (dec.rs2),
    .rs1Val  (rs1Val),
    .rs2Val  (rs2Val),
    .wbValid (wbValid),
    .wbRd    (wbRd),
    .wbVal   (wbVal)
  );

  // Attach operands read at issue time (re-read each cycle while buffered).
  always_comb begin
    issueUop        = dec;
    issueUop.rs1val = rs1Val;
    issueUop.rs2val = rs2Val;
  end

  // Issue when execute is not stalling; otherwise hold outputs and park the in-flight input.
  always_ff @(posedge clk) begin
    if (rst) begin
      bufFull  <= 1'b0;
      bufValid <= 1'b0;
      bufUop   <= '0;
      outValid <= 1'b0;
      uopOut   <= '0;
    end else if (d.stall) begin
      if (!bufFull) begin
        bufFull  <= 1'b1;
        bufValid <= u.valid;
        bufUop   <= uopIn;
      end
    end else begin
      outValid <= srcValid;
      uopOut   <= issueUop;
      bufFull  <= 1'b0;
    end
  end

endmodule
